// File: rtl/cv32e40x_ex_result_stage_if.sv
// EX-to-WB result interface: EX-side request/FU signals, forwarding, and the buffered head toward WB.
// The stage itself connects through the slave modport; the EX/WB environment uses the master modport.
interface cv32e40x_ex_result_stage_if #(
  parameter int XLEN   = 32,
  parameter int NUM_FU = 3,
  parameter int DEPTH  = 2
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                   halt_i;
  logic                   kill_i;
  logic                   flush_i;
  logic                   in_valid_i;
  logic [NUM_FU-1:0]      in_fu_sel_i;
  logic                   in_rf_we_i;
  logic [4:0]             in_rf_waddr_i;
  logic [XLEN-1:0]        in_pc_i;
  logic [NUM_FU-1:0]      fu_ready_i;
  logic [NUM_FU*XLEN-1:0] fu_result_i;
  logic                   in_ready_o;
  logic                   fwd_we_o;
  logic [4:0]             fwd_waddr_o;
  logic [XLEN-1:0]        fwd_wdata_o;
  logic                   out_valid_o;
  logic                   out_ready_i;
  logic                   out_rf_we_o;
  logic [4:0]             out_rf_waddr_o;
  logic [XLEN-1:0]        out_rf_wdata_o;
  logic [XLEN-1:0]        out_pc_o;
  logic [CW-1:0]          count_o;
  logic                   sel_err_o;

  modport master (
    output halt_i, kill_i, flush_i, in_valid_i, in_fu_sel_i, in_rf_we_i, in_rf_waddr_i,
           in_pc_i, fu_ready_i, fu_result_i, out_ready_i,
    input  in_ready_o, fwd_we_o, fwd_waddr_o, fwd_wdata_o, out_valid_o, out_rf_we_o,
           out_rf_waddr_o, out_rf_wdata_o, out_pc_o, count_o, sel_err_o
  );

  modport slave (
    input  halt_i, kill_i, flush_i, in_valid_i, in_fu_sel_i, in_rf_we_i, in_rf_waddr_i,
           in_pc_i, fu_ready_i, fu_result_i, out_ready_i,
    output in_ready_o, fwd_we_o, fwd_waddr_o, fwd_wdata_o, out_valid_o, out_rf_we_o,
           out_rf_waddr_o, out_rf_wdata_o, out_pc_o, count_o, sel_err_o
  );
endinterface

// File: rtl/cv32e40x_ex_result_stage.sv
// EX result stage: selects the finishing FU's result, forwards it to ID, and queues it
// in a small circular EX/WB buffer whose head is presented to WB from registers.
module cv32e40x_ex_result_stage #(
  parameter int XLEN   = 32,
  parameter int NUM_FU = 3,
  parameter int DEPTH  = 2
) (
  input logic                        clk,
  input logic                        rst_n,
  cv32e40x_ex_result_stage_if.slave  bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic            we;
    logic [4:0]      waddr;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] pc;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wptr_q;
  logic [PW-1:0]   rptr_q;
  logic [CW-1:0]   count_q;

  logic            sel_rdy;
  logic            sel_err;
  logic [XLEN-1:0] sel_or;
  logic [XLEN-1:0] result;
  logic            in_ready;
  logic            push;
  logic            pop;
  entry_t          wr_entry;

  // NOTE: combinational outputs get a default before any conditional update so no latch is inferred.
  always_comb begin
    sel_rdy = 1'b1;
    sel_or  = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      if (bus.in_fu_sel_i[k]) begin
        if (!bus.fu_ready_i[k]) sel_rdy = 1'b0;
        sel_or = sel_or | bus.fu_result_i[k*XLEN +: XLEN];
      end
    end
  end

  // A multi-hot select is a decode error; its OR'ed result must never reach the register file.
  assign sel_err  = bus.in_valid_i && ($countones(bus.in_fu_sel_i) > 1);
  assign result   = sel_err ? '0 : sel_or;

  assign in_ready = sel_rdy && !bus.halt_i && ((count_q < CW'(DEPTH)) || bus.out_ready_i);
  assign push     = bus.in_valid_i && in_ready && !bus.kill_i && !bus.flush_i;
  assign pop      = (count_q != '0) && bus.out_ready_i;

  always_comb begin
    wr_entry.we    = bus.in_rf_we_i;
    wr_entry.waddr = bus.in_rf_we_i ? bus.in_rf_waddr_i : 5'd0;
    wr_entry.wdata = bus.in_rf_we_i ? result : '0;
    wr_entry.pc    = bus.in_pc_i;
  end

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      // NOTE: the buffer entries are reset too, so the head outputs read as zero out of reset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (bus.flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem[wptr_q] <= wr_entry;
        wptr_q      <= ptr_inc(wptr_q);
      end
      if (pop) rptr_q <= ptr_inc(rptr_q);
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  assign bus.in_ready_o     = in_ready;
  assign bus.sel_err_o      = sel_err;
  assign bus.fwd_we_o       = bus.in_valid_i && bus.in_rf_we_i && !bus.kill_i;
  assign bus.fwd_waddr_o    = bus.in_rf_waddr_i;
  assign bus.fwd_wdata_o    = result;

  assign bus.count_o        = count_q;
  assign bus.out_valid_o    = (count_q != '0);
  assign bus.out_rf_we_o    = mem[rptr_q].we;
  assign bus.out_rf_waddr_o = mem[rptr_q].waddr;
  assign bus.out_rf_wdata_o = mem[rptr_q].wdata;
  assign bus.out_pc_o       = mem[rptr_q].pc;
endmodule

// File: tb/tb_cv32e40x_ex_result_stage.sv
// Testbench for cv32e40x_ex_result_stage: a directed table, hand-written corner sequences,
// and random traffic checked against a queue-based model of the result buffer.
module tb_cv32e40x_ex_result_stage;
  localparam int XLEN   = 32;
  localparam int NUM_FU = 3;
  localparam int DEPTH  = 2;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  cv32e40x_ex_result_stage_if #(.XLEN(XLEN), .NUM_FU(NUM_FU), .DEPTH(DEPTH)) bus ();

  cv32e40x_ex_result_stage #(.XLEN(XLEN), .NUM_FU(NUM_FU), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] pc;
  } ent_t;

  ent_t q[$];

  typedef struct {
    logic [2:0]  sel;
    logic [2:0]  rdy;
    logic        valid;
    logic        kill;
    logic        halt;
    logic        we;
    logic        exp_ready;
    logic        exp_err;
    logic        exp_fwd_we;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[8];

  localparam logic [31:0] R0 = 32'h0000_1234;
  localparam logic [31:0] R1 = 32'h0000_ABCD;
  localparam logic [31:0] R2 = 32'hDEAD_BEEF;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    bus.halt_i        = 1'b0;
    bus.kill_i        = 1'b0;
    bus.flush_i       = 1'b0;
    bus.in_valid_i    = 1'b0;
    bus.in_fu_sel_i   = '0;
    bus.in_rf_we_i    = 1'b0;
    bus.in_rf_waddr_i = '0;
    bus.in_pc_i       = '0;
    bus.fu_ready_i    = 3'b111;
    bus.fu_result_i   = '0;
    bus.out_ready_i   = 1'b0;
  endtask

  // One clock cycle: check every output against the model, then advance the model at the edge.
  task automatic step();
    int          n;
    logic        m_err, m_rdy, m_in_ready, m_push, m_pop, m_flush;
    logic [31:0] m_res;
    ent_t        e;
    #2;
    n      = $countones(bus.in_fu_sel_i);
    m_err  = bus.in_valid_i && (n > 1);
    m_rdy  = ((bus.in_fu_sel_i & ~bus.fu_ready_i) == 3'b000);
    m_res  = 32'h0;
    if (n == 1)
      for (int k = 0; k < NUM_FU; k++)
        if (bus.in_fu_sel_i[k]) m_res = bus.fu_result_i[k*XLEN +: XLEN];
    m_in_ready = m_rdy && !bus.halt_i && ((q.size() < DEPTH) || bus.out_ready_i);
    m_push     = bus.in_valid_i && m_in_ready && !bus.kill_i && !bus.flush_i;
    m_pop      = (q.size() != 0) && bus.out_ready_i;
    m_flush    = bus.flush_i;

    check("in_ready", bus.in_ready_o, m_in_ready);
    check("sel_err", bus.sel_err_o, m_err);
    check("fwd_we", bus.fwd_we_o, bus.in_valid_i && bus.in_rf_we_i && !bus.kill_i);
    check("fwd_waddr", bus.fwd_waddr_o, bus.in_rf_waddr_i);
    if (!(n > 1 && !bus.in_valid_i)) check("fwd_wdata", bus.fwd_wdata_o, m_res);
    check("out_valid", bus.out_valid_o, q.size() != 0);
    check("count", bus.count_o, q.size());
    if (q.size() != 0) begin
      check("out_we", bus.out_rf_we_o, q[0].we);
      check("out_waddr", bus.out_rf_waddr_o, q[0].waddr);
      check("out_wdata", bus.out_rf_wdata_o, q[0].wdata);
      check("out_pc", bus.out_pc_o, q[0].pc);
    end

    e.we    = bus.in_rf_we_i;
    e.waddr = bus.in_rf_we_i ? bus.in_rf_waddr_i : 5'd0;
    e.wdata = bus.in_rf_we_i ? m_res : 32'h0;
    e.pc    = bus.in_pc_i;

    @(posedge clk);
    if (m_flush) q.delete();
    else begin
      if (m_pop) void'(q.pop_front());
      if (m_push) q.push_back(e);
    end
    #1;
  endtask

  task automatic push_r0(input logic [31:0] data, input logic [4:0] waddr);
    bus.in_valid_i     = 1'b1;
    bus.in_fu_sel_i    = 3'b001;
    bus.fu_ready_i     = 3'b111;
    bus.in_rf_we_i     = 1'b1;
    bus.in_rf_waddr_i  = waddr;
    bus.in_pc_i        = 32'h8000_0000 + {data[29:0], 2'b00};
    bus.fu_result_i    = {R2, R1, data};
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{3'b001, 3'b111, 1, 0, 0, 1, 1, 0, 1, R0};
    vecs[1] = '{3'b010, 3'b101, 1, 0, 0, 1, 0, 0, 1, R1};
    vecs[2] = '{3'b100, 3'b100, 1, 0, 1, 1, 0, 0, 1, R2};
    vecs[3] = '{3'b000, 3'b000, 1, 0, 0, 1, 1, 0, 1, 32'h0};
    vecs[4] = '{3'b011, 3'b111, 1, 0, 0, 1, 1, 1, 1, 32'h0};
    vecs[5] = '{3'b011, 3'b111, 1, 1, 0, 1, 1, 1, 0, 32'h0};
    vecs[6] = '{3'b100, 3'b111, 1, 0, 0, 0, 1, 0, 0, R2};
    vecs[7] = '{3'b001, 3'b110, 1, 0, 0, 1, 0, 0, 1, R0};

    idle();
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", bus.out_valid_o, 1'b0);
    check("rst_count", bus.count_o, 0);
    check("rst_out_wdata", bus.out_rf_wdata_o, 0);
    check("rst_out_pc", bus.out_pc_o, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 check("post_rst_out_valid", bus.out_valid_o, 1'b0);
    @(posedge clk);
    #1;

    // Combinational table with flush held so the buffer stays empty.
    bus.flush_i     = 1'b1;
    bus.fu_result_i = {R2, R1, R0};
    bus.in_rf_waddr_i = 5'd9;
    for (int i = 0; i < 8; i++) begin
      bus.in_fu_sel_i = vecs[i].sel;
      bus.fu_ready_i  = vecs[i].rdy;
      bus.in_valid_i  = vecs[i].valid;
      bus.kill_i      = vecs[i].kill;
      bus.halt_i      = vecs[i].halt;
      bus.in_rf_we_i  = vecs[i].we;
      #2;
      check($sformatf("vec%0d_in_ready", i), bus.in_ready_o, vecs[i].exp_ready);
      check($sformatf("vec%0d_sel_err", i), bus.sel_err_o, vecs[i].exp_err);
      check($sformatf("vec%0d_fwd_we", i), bus.fwd_we_o, vecs[i].exp_fwd_we);
      check($sformatf("vec%0d_fwd_wdata", i), bus.fwd_wdata_o, vecs[i].exp_data);
      @(posedge clk);
      #1 check($sformatf("vec%0d_count", i), bus.count_o, 0);
    end
    idle();

    // Single op with same-cycle forwarding and one-cycle first-word latency.
    bus.out_ready_i = 1'b1;
    bus.in_valid_i  = 1'b1;
    bus.in_fu_sel_i = 3'b001;
    bus.in_rf_we_i  = 1'b1;
    bus.in_rf_waddr_i = 5'd5;
    bus.fu_result_i = {R2, R1, 32'h1234};
    #1 check("single_fwd_wdata", bus.fwd_wdata_o, 32'h1234);
    step();
    bus.in_valid_i = 1'b0;
    check("single_out_valid", bus.out_valid_o, 1'b1);
    check("single_out_wdata", bus.out_rf_wdata_o, 32'h1234);
    check("single_out_waddr", bus.out_rf_waddr_o, 5);
    check("single_count", bus.count_o, 1);
    step();
    idle();

    // Fill, backpressure, push into a full buffer alongside a pop, then drain in order.
    push_r0(32'hA, 5'd1);
    push_r0(32'hB, 5'd2);
    bus.fu_result_i = {R2, R1, 32'hC};
    bus.in_rf_waddr_i = 5'd3;
    #1;
    check("full_count", bus.count_o, 2);
    check("full_in_ready", bus.in_ready_o, 1'b0);
    step();
    bus.out_ready_i = 1'b1;
    push_r0(32'hC, 5'd3);
    check("full_swap_count", bus.count_o, 2);
    check("full_swap_head", bus.out_rf_wdata_o, 32'hB);
    bus.in_valid_i = 1'b0;
    step();
    check("drain_head", bus.out_rf_wdata_o, 32'hC);
    step();
    check("drain_empty", bus.count_o, 0);
    idle();

    // Multicycle FU: no acceptance until its ready arrives.
    bus.in_valid_i  = 1'b1;
    bus.in_fu_sel_i = 3'b010;
    bus.fu_ready_i  = 3'b000;
    bus.in_rf_we_i  = 1'b1;
    bus.in_rf_waddr_i = 5'd7;
    bus.fu_result_i = {R2, 32'h777, R0};
    for (int c = 0; c < 3; c++) begin
      #1 check("mc_in_ready", bus.in_ready_o, 1'b0);
      step();
      check("mc_no_push", bus.count_o, 0);
    end
    bus.fu_ready_i = 3'b010;
    step();
    check("mc_count", bus.count_o, 1);
    check("mc_wdata", bus.out_rf_wdata_o, 32'h777);
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    step();
    idle();

    // Kill leaves the buffer alone; flush empties it.
    push_r0(32'h11, 5'd4);
    push_r0(32'h22, 5'd6);
    bus.kill_i = 1'b1;
    #1 check("kill_fwd_we", bus.fwd_we_o, 1'b0);
    step();
    check("kill_count", bus.count_o, 2);
    bus.kill_i     = 1'b0;
    bus.in_valid_i = 1'b0;
    bus.flush_i    = 1'b1;
    step();
    check("flush_count", bus.count_o, 0);
    check("flush_out_valid", bus.out_valid_o, 1'b0);
    idle();

    // Multi-hot select flags an error and stores zero data.
    bus.in_valid_i  = 1'b1;
    bus.in_fu_sel_i = 3'b011;
    bus.in_rf_we_i  = 1'b1;
    bus.in_rf_waddr_i = 5'd3;
    bus.fu_result_i = {R2, R1, R0};
    #1 check("selerr_flag", bus.sel_err_o, 1'b1);
    step();
    check("selerr_out_valid", bus.out_valid_o, 1'b1);
    check("selerr_wdata", bus.out_rf_wdata_o, 32'h0);
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    step();
    idle();

    // Asynchronous reset in mid-cycle with a push in flight.
    push_r0(32'h31, 5'd8);
    push_r0(32'h32, 5'd9);
    bus.out_ready_i = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("arst_count", bus.count_o, 0);
    check("arst_out_valid", bus.out_valid_o, 1'b0);
    q.delete();
    @(posedge clk);
    #1 check("arst_push_dropped", bus.count_o, 0);
    idle();
    #3 rst_n = 1'b1;
    #1 check("arst_release_valid", bus.out_valid_o, 1'b0);
    @(posedge clk);
    #1;
    push_r0(32'h55, 5'd10);
    check("arst_push55", bus.out_rf_wdata_o, 32'h55);
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    step();
    idle();

    // Random traffic against the queue model.
    for (int c = 0; c < 400; c++) begin
      case ($urandom_range(0, 7))
        0:       bus.in_fu_sel_i = 3'b000;
        7:       bus.in_fu_sel_i = 3'($urandom_range(0, 7));
        default: bus.in_fu_sel_i = 3'(1 << $urandom_range(0, 2));
      endcase
      bus.fu_ready_i    = 3'($urandom_range(0, 7));
      bus.halt_i        = ($urandom_range(0, 7) == 0);
      bus.kill_i        = ($urandom_range(0, 7) == 0);
      bus.flush_i       = ($urandom_range(0, 15) == 0);
      bus.in_valid_i    = ($urandom_range(0, 3) != 0);
      bus.in_rf_we_i    = 1'($urandom_range(0, 1));
      bus.in_rf_waddr_i = 5'($urandom_range(0, 31));
      bus.in_pc_i       = $urandom;
      bus.fu_result_i   = {$urandom, $urandom, $urandom};
      bus.out_ready_i   = 1'($urandom_range(0, 1));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cv32e40x_ex_result_stage.md
CV32E40X_EX_RESULT_STAGE -- requirements
Module: cv32e40x_ex_result_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath width.
REQ-002 SHALL have parameter NUM_FU, default 3, legal range 1..8, meaning number of functional units (e.g. ALU, MULT, CSR).
REQ-003 SHALL have parameter DEPTH, default 2, legal range 1..4, meaning number of EX/WB buffer entries.
REQ-004 SHALL have ports:
- clk  in  1  clock.
- rst_n  in  1  reset: asynchronous, active-low.
- halt_i  in  1  blocks acceptance.
- kill_i  in  1  discards the instruction currently offered.
- flush_i  in  1  empties the buffer.
- in_valid_i  in  1  instruction present in EX.
- in_fu_sel_i  in  NUM_FU  one-hot FU select; all-zero means no FU.
- in_rf_we_i  in  1  register write enable.
- in_rf_waddr_i  in  5  destination register.
- in_pc_i  in  XLEN  instruction PC.
- fu_ready_i  in  NUM_FU  per-FU done.
- fu_result_i  in  NUM_FU*XLEN  per-FU result; FU k occupies bits [k*XLEN +: XLEN].
- in_ready_o  out  1  EX ready.
- fwd_we_o  out  1  forwarding write enable to ID.
- fwd_waddr_o  out  5  forwarding address.
- fwd_wdata_o  out  XLEN  forwarding data.
- out_valid_o  out  1  head entry valid.
- out_ready_i  in  1  WB accepts head.
- out_rf_we_o  out  1  head write enable.
- out_rf_waddr_o  out  5  head address.
- out_rf_wdata_o  out  XLEN  head data.
- out_pc_o  out  XLEN  head PC.
- count_o  out  $clog2(DEPTH+1)  occupancy.
- sel_err_o  out  1  in_fu_sel_i is not one-hot or zero while in_valid_i=1.

Function
REQ-005 SHALL compute sel_rdy = AND of fu_ready_i[k] over all k with in_fu_sel_i[k]=1; sel_rdy=1 when in_fu_sel_i is zero.
REQ-006 SHALL drive in_ready_o = sel_rdy && !halt_i && (count_o<DEPTH || out_ready_i), combinationally.
REQ-007 SHALL define push = in_valid_i && in_ready_o && !kill_i && !flush_i.
REQ-008 SHALL define pop = out_valid_o && out_ready_i.
REQ-009 SHALL select the result as fu_result_i of the selected FU; result SHALL be 0 when the select is zero or sel_err_o=1.
REQ-010 SHALL drive fwd_we_o = in_valid_i && in_rf_we_i && !kill_i, fwd_waddr_o = in_rf_waddr_i, and fwd_wdata_o = result, all combinationally, independent of the ready signals.
REQ-011 SHALL write {in_rf_we_i, in_rf_waddr_i, result, in_pc_i} to the tail entry on push; on a push with in_rf_we_i=0, the stored waddr and wdata SHALL be 0.
REQ-012 SHALL use circular read/write pointers of $clog2(DEPTH) bits (1 bit when DEPTH=1) that wrap from DEPTH-1 to 0.
REQ-013 SHALL update count on the clock edge: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-014 SHALL allow a push when full only if a pop occurs in the same cycle, with no data loss.
REQ-015 SHALL drive out_valid_o = (count_o != 0); out_* fields SHALL reflect the head entry, which is registered (no combinational input-to-output path).
REQ-016 SHALL make the first-word latency 1 cycle: a push in cycle N gives out_valid_o=1 in cycle N+1.
REQ-017 SHALL, on flush_i=1, reset both pointers and count to 0 at the next edge; flush SHALL override push and pop; entry contents are don't-care.
REQ-018 SHALL, on kill_i=1, suppress push and fwd_we_o only; buffered entries are unaffected.
REQ-019 SHALL leave halt_i with no effect on pop or forwarding.
REQ-020 SHALL assert sel_err_o combinationally when in_valid_i=1 and $countones(in_fu_sel_i) > 1.
REQ-021 SHALL preserve FIFO ordering: entries leave in push order.

Reset
REQ-022 SHALL, on rst_n low, asynchronously clear pointers, count_o, and all entry fields to 0.
REQ-023 SHALL drive out_valid_o=0 during reset and in the first cycle after reset release.
REQ-024 SHALL discard any in-flight push coincident with reset assertion.

Verification
REQ-025 Single op: sel=3'b001, fu_ready=3'b111, result0=0x1234, waddr=5, out_ready=1 -> fwd_wdata=0x1234 same cycle; next cycle out_valid=1, wdata=0x1234, waddr=5, count=1.
REQ-026 Fill/backpressure: DEPTH=2, out_ready=0, push 0xA then 0xB -> count=2, in_ready_o=0; then out_ready=1 plus push 0xC -> pops 0xA, stores 0xC, count stays 2; drain order is 0xB, 0xC.
REQ-027 Multicycle FU: sel=3'b010, fu_ready[1]=0 for 3 cycles -> in_ready_o=0 and no push for 3 cycles; push on the 4th cycle with result1.
REQ-028 Kill/flush: kill_i=1 with in_valid=1 -> count unchanged, fwd_we_o=0; flush_i=1 with count=2 -> count=0, out_valid=0 next cycle.
REQ-029 Select error: sel=3'b011 -> sel_err_o=1, and the pushed wdata=0.
REQ-030 Reset mid-operation: count=2, assert rst_n=0 asynchronously -> count_o=0 and out_valid_o=0 immediately; after release, a push of 0x55 gives out_wdata=0x55.
